// File: rtl/dft_bin_accumulator_pkg.sv
// Shared sizing constants and FSM state encoding for the DFT bin accumulator.
package dft_pkg;

    localparam int NUM_BINS  = 24;
    localparam int FRAME_LEN = 64;
    localparam int ACC_W     = 38;
    localparam int SAMPLE_W  = 16;
    localparam int LUT_W     = 16;
    localparam int PROD_W    = SAMPLE_W + LUT_W;
    localparam int BIN_W     = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MAC     = 2'd1,
        S_ADVANCE = 2'd2
    } dft_state_e;

endpackage

// File: rtl/dft_bin_accumulator_if.sv
// Sample input, trig-table handshake and result read port of the DFT bin accumulator.
interface dft_bin_accumulator_if;
    import dft_pkg::*;

    logic signed [SAMPLE_W-1:0] sample_in;
    logic                       sample_valid;
    logic                       sample_ready;
    logic [BIN_W-1:0]           lut_bin;
    logic                       lut_incr;
    logic signed [LUT_W-1:0]    lut_sin;
    logic signed [LUT_W-1:0]    lut_cos;
    logic [BIN_W-1:0]           rd_bin;
    logic signed [ACC_W-1:0]    rd_real;
    logic signed [ACC_W-1:0]    rd_imag;
    logic                       frame_valid;

    modport master (
        output sample_in, sample_valid, lut_sin, lut_cos, rd_bin,
        input  sample_ready, lut_bin, lut_incr, rd_real, rd_imag, frame_valid
    );

    modport slave (
        input  sample_in, sample_valid, lut_sin, lut_cos, rd_bin,
        output sample_ready, lut_bin, lut_incr, rd_real, rd_imag, frame_valid
    );

endinterface

// File: rtl/dft_bin_accumulator_mac_lane.sv
// One multiply-accumulate lane: per-bin accumulator, published result bank, registered read.
module dft_mac_lane #(
    parameter int NUM_BINS = dft_pkg::NUM_BINS,
    parameter int ACC_W    = dft_pkg::ACC_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  mac_en,
    input  logic                                  overwrite,
    input  logic [dft_pkg::BIN_W-1:0]             bin,
    input  logic signed [dft_pkg::SAMPLE_W-1:0]   sample,
    input  logic signed [dft_pkg::LUT_W-1:0]      coef,
    input  logic                                  publish,
    input  logic [dft_pkg::BIN_W-1:0]             rd_bin,
    output logic signed [ACC_W-1:0]               rd_data
);
    import dft_pkg::*;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc  [NUM_BINS];
    logic signed [ACC_W-1:0]  bank [NUM_BINS];

    assign prod     = sample * coef;
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // First sample of a frame overwrites, so no clear pass is needed between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                acc[i]  <= '0;
                bank[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (mac_en && (bin < BIN_W'(NUM_BINS))) begin
                acc[bin] <= overwrite ? prod_ext : acc[bin] + prod_ext;
            end
            if (publish) begin
                for (int i = 0; i < NUM_BINS; i++) begin
                    bank[i] <= acc[i];
                end
            end
            rd_data <= (rd_bin < BIN_W'(NUM_BINS)) ? bank[rd_bin] : '0;
        end
    end

endmodule

// File: rtl/dft_bin_accumulator.sv
// Per-sample sequencer sweeping every bin through the cos/sin MAC lanes, publishing a bank per frame.
//   state      | meaning
//   ST_IDLE    | ready for a sample; latch it on valid
//   ST_MAC     | one bin per cycle, lut_bin = 0..NUM_BINS-1
//   ST_ADVANCE | lut_incr pulse, step sample_count, publish on last sample
module dft_bin_accumulator #(
    parameter int NUM_BINS  = dft_pkg::NUM_BINS,
    parameter int FRAME_LEN = dft_pkg::FRAME_LEN,
    parameter int ACC_W     = dft_pkg::ACC_W
) (
    input logic                  clk,
    input logic                  rst,
    dft_bin_accumulator_if.slave bus
);
    import dft_pkg::*;

    localparam int CNT_W = $clog2(FRAME_LEN);

    localparam logic [1:0] ST_IDLE    = S_IDLE;
    localparam logic [1:0] ST_MAC     = S_MAC;
    localparam logic [1:0] ST_ADVANCE = S_ADVANCE;

    logic [1:0]                 state;
    logic [BIN_W-1:0]           bin_cnt;
    logic [CNT_W-1:0]           sample_count;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic                       frame_valid_q;
    logic                       mac_en;
    logic                       mac_last;
    logic                       frame_last;
    logic                       overwrite;
    logic                       publish;

    assign mac_en     = (state == ST_MAC);
    assign mac_last   = (bin_cnt == BIN_W'(NUM_BINS - 1));
    assign frame_last = (sample_count == CNT_W'(FRAME_LEN - 1));
    assign overwrite  = (sample_count == '0);
    assign publish    = (state == ST_ADVANCE) && frame_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bin_cnt       <= '0;
            sample_count  <= '0;
            sample_q      <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= publish;
            case (state)
                ST_IDLE: begin
                    if (bus.sample_valid) begin
                        sample_q <= bus.sample_in;
                        bin_cnt  <= '0;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (mac_last) begin
                        state <= ST_ADVANCE;
                    end else begin
                        bin_cnt <= bin_cnt + 1'b1;
                    end
                end
                ST_ADVANCE: begin
                    sample_count <= frame_last ? '0 : sample_count + 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sample_ready = (state == ST_IDLE);
    assign bus.lut_bin      = mac_en ? bin_cnt : '0;
    assign bus.lut_incr     = (state == ST_ADVANCE);
    assign bus.frame_valid  = frame_valid_q;

    dft_mac_lane #(.NUM_BINS(NUM_BINS), .ACC_W(ACC_W)) u_lane_real (
        .clk       (clk),
        .rst       (rst),
        .mac_en    (mac_en),
        .overwrite (overwrite),
        .bin       (bin_cnt),
        .sample    (sample_q),
        .coef      (bus.lut_cos),
        .publish   (publish),
        .rd_bin    (bus.rd_bin),
        .rd_data   (bus.rd_real)
    );

    dft_mac_lane #(.NUM_BINS(NUM_BINS), .ACC_W(ACC_W)) u_lane_imag (
        .clk       (clk),
        .rst       (rst),
        .mac_en    (mac_en),
        .overwrite (overwrite),
        .bin       (bin_cnt),
        .sample    (sample_q),
        .coef      (bus.lut_sin),
        .publish   (publish),
        .rd_bin    (bus.rd_bin),
        .rd_data   (bus.rd_imag)
    );

endmodule

// File: tb/tb_dft_bin_accumulator.sv
// Directed bench: constant-LUT frame vectors plus sequences for timing, frame restart, reset and throughput.
module tb_dft_bin_accumulator;
    import dft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dft_bin_accumulator_if bus();
    dft_bin_accumulator dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Trig table model: constant mode or a position/bin dependent pattern.
    int                 lut_mode;
    logic signed [15:0] c_sin;
    logic signed [15:0] c_cos;
    int                 pos;

    function automatic int cos_f(input int p, input int b);
        return (p * 37 + b * 11) % 200 - 100;
    endfunction

    function automatic int sin_f(input int p, input int b);
        return (p * 13 + b * 29) % 300 - 150;
    endfunction

    always @(posedge clk) begin
        if (rst) pos <= 0;
        else if (bus.lut_incr) pos <= (pos + 1) % FRAME_LEN;
    end

    always_comb begin
        bus.lut_cos = c_cos;
        bus.lut_sin = c_sin;
        if (lut_mode == 1) begin
            bus.lut_cos = 16'(cos_f(pos, int'(bus.lut_bin)));
            bus.lut_sin = 16'(sin_f(pos, int'(bus.lut_bin)));
        end
    end

    int cyc = 0;
    int fv_count = 0;
    int incr_count = 0;
    int acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.frame_valid) fv_count++;
        if (bus.lut_incr) incr_count++;
        if (bus.sample_valid && bus.sample_ready) acc_cyc.push_back(cyc);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        bus.rd_bin = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!bus.sample_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.sample_ready) chk("wait_idle_timeout", 64'(bus.sample_ready), 1);
    endtask

    task automatic send(input logic signed [15:0] s);
        wait_idle();
        bus.sample_in = s;
        bus.sample_valid = 1'b1;
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
    endtask

    task automatic run_frame(input logic signed [15:0] s, input int n);
        repeat (n) send(s);
        wait_idle();
        @(posedge clk); #1;
    endtask

    logic signed [63:0] exp_re[NUM_BINS];
    logic signed [63:0] exp_im[NUM_BINS];

    task automatic check_bins(input string tag);
        for (int b = 0; b < NUM_BINS; b++) begin
            bus.rd_bin = 5'(b);
            @(posedge clk); #1;
            chk($sformatf("%s_re[%0d]", tag, b), bus.rd_real, exp_re[b]);
            chk($sformatf("%s_im[%0d]", tag, b), bus.rd_imag, exp_im[b]);
        end
        bus.rd_bin = 5'd31;
        @(posedge clk); #1;
        chk({tag, "_rd31_re"}, bus.rd_real, 0);
        chk({tag, "_rd31_im"}, bus.rd_imag, 0);
    endtask

    typedef struct {
        string              name;
        logic signed [15:0] smp;
        logic signed [15:0] sinv;
        logic signed [15:0] cosv;
        logic signed [63:0] exp_re;
        logic signed [63:0] exp_im;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int fv0, inc0, q0, low, n;
        logic signed [63:0] sum_c[NUM_BINS];
        logic signed [63:0] sum_s[NUM_BINS];
        logic signed [63:0] old_re5;

        vecs[0] = '{"unit",    16'sh0100, 16'sh0100, 16'sh0100, 64'sh400000,     64'sh400000};
        vecs[1] = '{"extreme", 16'sh8000, 16'sh8000, 16'sh8000, 64'sh1000000000, 64'sh1000000000};
        vecs[2] = '{"mixed",   16'sh0100, 16'sh8000, 16'sh7FFF, 64'sh1FFFC000,   -64'sh20000000};
        vecs[3] = '{"neg",     -16'sd1,   -16'sd5,   16'sd3,    -64'sd192,       64'sd320};

        for (int b = 0; b < NUM_BINS; b++) begin
            sum_c[b] = 0;
            sum_s[b] = 0;
            for (int p = 0; p < FRAME_LEN; p++) begin
                sum_c[b] += cos_f(p, b);
                sum_s[b] += sin_f(p, b);
            end
        end

        lut_mode = 0;
        c_sin = '0;
        c_cos = '0;
        bus.sample_in = '0;
        do_reset();

        chk("rst_ready", 64'(bus.sample_ready), 1);
        chk("rst_lut_bin", 64'(bus.lut_bin), 0);
        chk("rst_lut_incr", 64'(bus.lut_incr), 0);
        chk("rst_frame_valid", 64'(bus.frame_valid), 0);
        chk("rst_rd_real", bus.rd_real, 0);
        chk("rst_rd_imag", bus.rd_imag, 0);

        // Constant-table frames.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            lut_mode = 0;
            c_sin = vecs[v].sinv;
            c_cos = vecs[v].cosv;
            fv0 = fv_count;
            run_frame(vecs[v].smp, FRAME_LEN);
            chk({vecs[v].name, "_frames"}, 64'(fv_count - fv0), 1);
            for (int b = 0; b < NUM_BINS; b++) begin
                exp_re[b] = vecs[v].exp_re;
                exp_im[b] = vecs[v].exp_im;
            end
            check_bins(vecs[v].name);
        end

        // Single sample: bin sweep, one lut_incr, 25 busy cycles.
        do_reset();
        inc0 = incr_count;
        low = 0;
        send(16'sd5);
        for (int i = 0; i < NUM_BINS; i++) begin
            chk($sformatf("sweep_lut_bin%0d", i), 64'(bus.lut_bin), i);
            if (!bus.sample_ready) low++;
            @(posedge clk); #1;
        end
        chk("sweep_adv_incr", 64'(bus.lut_incr), 1);
        if (!bus.sample_ready) low++;
        @(posedge clk); #1;
        chk("sweep_ready_back", 64'(bus.sample_ready), 1);
        chk("sweep_lut_bin_idle", 64'(bus.lut_bin), 0);
        chk("sweep_busy_cycles", 64'(low), 25);
        chk("sweep_incr_pulses", 64'(incr_count - inc0), 1);

        // Two frames with varying table; frame 2 must not carry frame 1 over.
        do_reset();
        lut_mode = 1;
        fv0 = fv_count;
        run_frame(16'sh1234, FRAME_LEN);
        for (int b = 0; b < NUM_BINS; b++) begin
            exp_re[b] = 64'sd4660 * sum_c[b];
            exp_im[b] = 64'sd4660 * sum_s[b];
        end
        old_re5 = exp_re[5];
        check_bins("f1");
        bus.rd_bin = 5'd5;
        repeat (FRAME_LEN) send(16'sd1);
        wait_idle();
        chk("f2_publish_pulse", 64'(bus.frame_valid), 1);
        chk("f2_read_old", bus.rd_real, old_re5);
        @(posedge clk); #1;
        chk("f2_read_new", bus.rd_real, sum_c[5]);
        chk("f2_frames", 64'(fv_count - fv0), 2);
        for (int b = 0; b < NUM_BINS; b++) begin
            exp_re[b] = sum_c[b];
            exp_im[b] = sum_s[b];
        end
        check_bins("f2");

        // Reset in the middle of a MAC sweep.
        do_reset();
        lut_mode = 1;
        repeat (30) send(16'sd3);
        send(16'sd3);
        n = 0;
        while (bus.lut_bin != 5'd10 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_reached_bin10", 64'(bus.lut_bin), 10);
        fv0 = fv_count;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_ready", 64'(bus.sample_ready), 1);
        chk("midrst_rd_real", bus.rd_real, 0);
        run_frame(-16'sd2, FRAME_LEN);
        chk("midrst_frames", 64'(fv_count - fv0), 1);
        for (int b = 0; b < NUM_BINS; b++) begin
            exp_re[b] = -64'sd2 * sum_c[b];
            exp_im[b] = -64'sd2 * sum_s[b];
        end
        check_bins("midrst");

        // Continuous valid: one acceptance per NUM_BINS+2 cycles.
        do_reset();
        lut_mode = 0;
        c_sin = 16'sd1;
        c_cos = 16'sd1;
        q0 = acc_cyc.size();
        bus.sample_in = 16'sd7;
        bus.sample_valid = 1'b1;
        repeat (26 * 5 + 2) @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        chk("stream_accepts", 64'(acc_cyc.size() - q0), 6);
        for (int i = q0 + 1; i < acc_cyc.size(); i++) begin
            chk($sformatf("stream_gap%0d", i - q0), 64'(acc_cyc[i] - acc_cyc[i-1]), 26);
        end
        wait_idle();
        bus.rd_bin = 5'd31;
        @(posedge clk); #1;
        chk("stream_rd31_re", bus.rd_real, 0);
        chk("stream_rd31_im", bus.rd_imag, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dft_bin_accumulator.md
DFT_BIN_ACCUMULATOR -- requirements
Module: dft_bin_accumulator

Interface
REQ-001 Parameter NUM_BINS, default 24: bins processed per sample; indices 0..NUM_BINS-1.
REQ-002 Parameter FRAME_LEN, default 64: samples per frame; equals the trig LUT position period.
REQ-003 Parameter ACC_W, default 38: signed accumulator and result width.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sample_in  input  16  signed audio sample.
REQ-007 sample_valid  input  1  sample_in is valid this cycle.
REQ-008 sample_ready  output  1  block can accept a sample this cycle.
REQ-009 lut_bin  output  5  bin index driven to the sin and cos tables.
REQ-010 lut_incr  output  1  one-cycle pulse that advances the table position counter.
REQ-011 lut_sin  input  16  signed sin table value for lut_bin, available in the same cycle.
REQ-012 lut_cos  input  16  signed cos table value for lut_bin, available in the same cycle.
REQ-013 rd_bin  input  5  result bin select.
REQ-014 rd_real  output  ACC_W  registered cos-sum result for rd_bin.
REQ-015 rd_imag  output  ACC_W  registered sin-sum result for rd_bin.
REQ-016 frame_valid  output  1  one-cycle pulse when a new result bank is published.

Function
REQ-017 The FSM SHALL have three states: IDLE, MAC and ADVANCE.
REQ-018 sample_ready SHALL be 1 only in IDLE; sample_valid outside IDLE is ignored.
REQ-019 A sample SHALL be accepted and latched in the IDLE cycle where valid and ready are both 1; the FSM then moves to MAC.
REQ-020 MAC SHALL last NUM_BINS cycles, with lut_bin equal to 0,1,...,NUM_BINS-1 in successive cycles; lut_bin SHALL be 0 outside MAC.
REQ-021 In each MAC cycle, re[b] SHALL be updated with the sign-extended full 32-bit product sample*lut_cos, and im[b] with sample*lut_sin.
REQ-022 On the first sample of a frame (sample_count==0), the accumulator update SHALL overwrite; on every other sample it SHALL add; no separate clear cycles are allowed.
REQ-023 The arithmetic SHALL be two's complement; 64 times the maximum product fits in 38 bits, so saturation logic is not required.
REQ-024 ADVANCE SHALL last one cycle: lut_incr=1, sample_count increments modulo FRAME_LEN, then the FSM returns to IDLE.
REQ-025 Throughput SHALL be one sample per NUM_BINS+2 cycles (26 cycles at default).
REQ-026 In ADVANCE with sample_count==FRAME_LEN-1, the accumulators SHALL be copied to the result bank at the end of that cycle, and frame_valid SHALL be 1 in the following cycle.
REQ-027 rd_real and rd_imag SHALL have one-cycle read latency from rd_bin; if rd_bin>=NUM_BINS, both SHALL read 0.
REQ-028 A read that coincides with a bank publish SHALL return old data in that cycle and new data from the next cycle.
REQ-029 lut_incr SHALL pulse exactly once per accepted sample, so the table position stays equal to sample_count.

Reset
REQ-030 rst SHALL force IDLE and clear sample_count, latched sample, accumulators, result bank, rd_real, rd_imag, frame_valid and lut_incr to 0.
REQ-031 rst SHALL be the same reset as the trig tables, so the table position and sample_count both restart at 0.
REQ-032 rst mid-MAC SHALL abandon the partial frame; no frame_valid is produced for it.

Structure
REQ-033 Package dft_pkg SHALL hold NUM_BINS, FRAME_LEN, ACC_W, the sample and LUT width constants, and the state enum typedef.
REQ-034 Sub-module dft_mac_lane SHALL implement one multiply, overwrite-or-add and NUM_BINS-entry accumulator; it is instantiated twice, once for cos/real and once for sin/imag.

Verification
REQ-035 Run 64 samples of 0x0100 with the LUT model returning 0x0100 for sin and cos -> frame_valid once; every bin reads real=imag=0x400000.
REQ-036 Run 64 samples of 0x8000 with the LUT model returning 0x8000 for both -> every bin reads 0x1000000000 (the extreme positive sum, no overflow).
REQ-037 Run a single accepted sample -> lut_bin steps 0..23 in consecutive cycles, lut_incr pulses once, and sample_ready is low for exactly 25 cycles.
REQ-038 Run 128 samples in which frame 2 uses a constant value of 1 -> frame 2 results equal exactly 64*lut values, with no carry-over from frame 1.
REQ-039 Assert rst at MAC bin 10 of sample 30, then run 64 samples -> exactly one frame_valid, and results match a fresh-frame model.
REQ-040 Hold sample_valid continuously -> one sample is accepted every 26 cycles; rd_bin=31 returns 0.
